// File: rtl/pad.sv
// Row padder: forwards a raw pixel stream and appends WIDTH_NB-1 pad words
// after every cfg_width pixels so a downstream sliding-window filter can
// flush each row. Upstream is stalled while pad words are inserted.
// Output is a single registered stage with valid/ready on both sides.
module pad #(
  parameter int WIDTH_NB   = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] cfg_width,
  input  logic [IMG_WIDTH-1:0]  cfg_value,
  input  logic                  cfg_set,
  input  logic [IMG_WIDTH-1:0]  up_data,
  input  logic                  up_val,
  output logic                  up_rdy,
  output logic [IMG_WIDTH-1:0]  dn_data,
  output logic                  dn_val,
  input  logic                  dn_rdy
);

  // pad_cnt must be able to hold WIDTH_NB-1; keep at least one bit when no padding is used
  localparam int PAD_W = (WIDTH_NB > 1) ? $clog2(WIDTH_NB) : 1;
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'((WIDTH_NB > 1) ? WIDTH_NB - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_PAD
  } state_t;

  state_t                state_q, state_d;
  logic [MEM_AWIDTH-1:0] width_q, width_d;
  logic [IMG_WIDTH-1:0]  value_q, value_d;
  logic [MEM_AWIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [PAD_W-1:0]      pad_cnt_q, pad_cnt_d;
  logic                  dn_val_q, dn_val_d;
  logic [IMG_WIDTH-1:0]  dn_data_q, dn_data_d;

  logic                  out_free;
  logic                  up_rdy_int;
  logic                  row_last;

  // Output register can take a new word when empty or being drained this cycle
  assign out_free   = !dn_val_q || dn_rdy;
  assign up_rdy_int = (state_q == ST_PASS) && out_free && !cfg_set;
  assign row_last   = (col_cnt_q == (width_q - MEM_AWIDTH'(1)));

  assign up_rdy  = up_rdy_int;
  assign dn_val  = dn_val_q;
  assign dn_data = dn_data_q;

  // Next-state logic: cfg_set overrides everything, otherwise pass pixels or emit pad words
  always_comb begin
    logic                 produce;
    logic [IMG_WIDTH-1:0] word;

    state_d   = state_q;
    width_d   = width_q;
    value_d   = value_q;
    col_cnt_d = col_cnt_q;
    pad_cnt_d = pad_cnt_q;
    dn_val_d  = dn_val_q;
    dn_data_d = dn_data_q;
    produce   = 1'b0;
    word      = '0;

    if (cfg_set) begin
      width_d   = cfg_width;
      value_d   = cfg_value;
      col_cnt_d = '0;
      pad_cnt_d = '0;
      dn_val_d  = 1'b0;
      state_d   = (cfg_width != '0) ? ST_PASS : ST_IDLE;
    end else begin
      case (state_q)
        ST_PASS: begin
          if (up_val && up_rdy_int) begin
            produce = 1'b1;
            word    = up_data;
            if (row_last) begin
              col_cnt_d = '0;
              if (WIDTH_NB > 1) begin
                state_d   = ST_PAD;
                pad_cnt_d = '0;
              end
            end else begin
              col_cnt_d = col_cnt_q + MEM_AWIDTH'(1);
            end
          end
        end
        ST_PAD: begin
          if (out_free) begin
            produce = 1'b1;
            word    = value_q;
            if (pad_cnt_q == PAD_LAST) begin
              state_d   = ST_PASS;
              pad_cnt_d = '0;
            end else begin
              pad_cnt_d = pad_cnt_q + PAD_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (out_free) begin
        dn_val_d = produce;
        if (produce) begin
          dn_data_d = word;
        end
      end
    end
  end

  // State, config and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      value_q   <= '0;
      col_cnt_q <= '0;
      pad_cnt_q <= '0;
      dn_val_q  <= 1'b0;
      dn_data_q <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      value_q   <= value_d;
      col_cnt_q <= col_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      dn_val_q  <= dn_val_d;
      dn_data_q <= dn_data_d;
    end
  end

endmodule

// File: tb/tb_pad.sv
// Testbench for pad: directed scenarios plus randomized rounds, checked
// cycle by cycle against a transaction-level model and, per scenario,
// against the expected output word sequence built from the row rules.
module tb_pad;

  localparam int WNB = 3;
  localparam int IW  = 8;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_width;
  logic [IW-1:0] cfg_value;
  logic          cfg_set;
  logic [IW-1:0] up_data;
  logic          up_val;
  logic          up_rdy;
  logic [IW-1:0] dn_data;
  logic          dn_val;
  logic          dn_rdy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit            m_active;
  bit            m_val;
  logic [IW-1:0] m_data;
  logic [IW-1:0] m_value;
  int            m_width;
  int            m_col;
  int            m_pads;

  logic [IW-1:0] src_q[$];
  logic [IW-1:0] log_q[$];
  logic [IW-1:0] exp_q[$];
  int            dn_mode;
  int            cyc = 0;

  pad #(.WIDTH_NB(WNB), .IMG_WIDTH(IW), .MEM_AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_width (cfg_width),
    .cfg_value (cfg_value),
    .cfg_set   (cfg_set),
    .up_data   (up_data),
    .up_val    (up_val),
    .up_rdy    (up_rdy),
    .dn_data   (dn_data),
    .dn_val    (dn_val),
    .dn_rdy    (dn_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_val    = 1'b0;
    m_data   = '0;
    m_value  = '0;
    m_width  = 0;
    m_col    = 0;
    m_pads   = 0;
  endtask

  // Drive upstream from the source queue and downstream ready from the chosen pattern
  task automatic applyStimulus();
    up_val  = (src_q.size() > 0);
    up_data = up_val ? src_q[0] : '0;
    case (dn_mode)
      0:       dn_rdy = 1'b1;
      1:       dn_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       dn_rdy = 1'($urandom_range(0, 1));
      default: dn_rdy = 1'b0;
    endcase
  endtask

  // Compare DUT against the model, then advance the model over the coming edge
  task automatic checkOutput();
    bit            exp_rdy;
    bit            free;
    bit            prod;
    logic [IW-1:0] w;
    free    = !m_val || dn_rdy;
    exp_rdy = m_active && (m_pads == 0) && free && !cfg_set;
    check("dn_val", 32'(dn_val), 32'(m_val));
    if (m_val) check("dn_data", 32'(dn_data), 32'(m_data));
    check("up_rdy", 32'(up_rdy), 32'(exp_rdy));

    if (m_val && dn_rdy) log_q.push_back(m_data);
    if (cfg_set) begin
      m_width  = int'(cfg_width);
      m_value  = cfg_value;
      m_col    = 0;
      m_pads   = 0;
      m_val    = 1'b0;
      m_active = (cfg_width != '0);
    end else begin
      prod = 1'b0;
      w    = '0;
      if (m_active && (m_pads > 0) && free) begin
        prod = 1'b1;
        w    = m_value;
        m_pads--;
      end else if (exp_rdy && up_val) begin
        prod = 1'b1;
        w    = up_data;
        void'(src_q.pop_front());
        m_col++;
        if (m_col == m_width) begin
          m_col  = 0;
          m_pads = WNB - 1;
        end
      end
      if (free) begin
        m_val = prod;
        if (prod) m_data = w;
      end
    end
  endtask

  task automatic step();
    applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doCfg(input int width, input logic [IW-1:0] value);
    cfg_width = AW'(width);
    cfg_value = value;
    cfg_set   = 1'b1;
    step();
    cfg_set   = 1'b0;
  endtask

  task automatic runUntilDone(input string tag);
    int budget;
    budget = 0;
    while (!(src_q.size() == 0 && m_pads == 0 && !m_val) && budget < 500) begin
      step();
      budget++;
    end
    if (budget >= 500) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Expected stream from the row rules: each pixel, plus a pad burst after every full row
  task automatic buildExpected(input logic [IW-1:0] pix[$], input int width, input logic [IW-1:0] value);
    exp_q.delete();
    for (int i = 0; i < pix.size(); i++) begin
      exp_q.push_back(pix[i]);
      if (((i + 1) % width) == 0)
        for (int k = 0; k < WNB - 1; k++) exp_q.push_back(value);
    end
  endtask

  task automatic compareLog(input string tag);
    int n;
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic sendRun(input string tag, input logic [IW-1:0] pix[$], input int width,
                         input logic [IW-1:0] value, input int mode);
    dn_mode = mode;
    doCfg(width, value);
    log_q.delete();
    src_q = pix;
    runUntilDone(tag);
    buildExpected(pix, width, value);
    compareLog(tag);
  endtask

  initial begin
    logic [IW-1:0] pix[$];
    int            budget;

    rst       = 1'b1;
    cfg_width = '0;
    cfg_value = '0;
    cfg_set   = 1'b0;
    up_val    = 1'b0;
    up_data   = '0;
    dn_rdy    = 1'b1;
    dn_mode   = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dn_val", 32'(dn_val), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    check("rst_up_rdy", 32'(up_rdy), 32'd0);
    rst = 1'b0;

    // Idle without configuration: upstream offered but never accepted
    src_q = '{8'h55};
    repeat (20) step();
    src_q.delete();
    log_q.delete();

    // Basic padding and back-pressure on the same row layout
    pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    sendRun("basic", pix, 4, 8'hFF, 0);
    sendRun("bp", pix, 4, 8'hFF, 1);

    // One-pixel rows
    pix = '{8'hA0, 8'hB0};
    sendRun("w1", pix, 1, 8'hFF, 0);

    // Reconfigure while the first pad word sits stalled in the output register
    dn_mode = 0;
    doCfg(4, 8'hFF);
    log_q.delete();
    src_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    budget = 0;
    while (!(log_q.size() == 4 && m_val && m_data == 8'hFF) && budget < 50) begin
      step();
      budget++;
    end
    if (budget >= 50) check("reconf_timeout", 32'd1, 32'd0);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    compareLog("reconf_pre");
    dn_mode = 3;
    doCfg(2, 8'h00);
    dn_mode = 0;
    src_q = '{8'd9, 8'd10, 8'd11};
    runUntilDone("reconf");
    exp_q = '{8'd9, 8'd10, 8'h00, 8'h00, 8'd11};
    compareLog("reconf");

    // Asynchronous reset mid-row, then restart from column zero
    dn_mode = 0;
    doCfg(4, 8'hFF);
    src_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    budget = 0;
    while (src_q.size() > 2 && budget < 50) begin
      step();
      budget++;
    end
    if (budget >= 50) check("arst_timeout", 32'd1, 32'd0);
    check("pre_rst_val", 32'(dn_val), 32'(m_val));
    #2;
    rst = 1'b1;
    #1;
    check("arst_dn_val", 32'(dn_val), 32'd0);
    check("arst_up_rdy", 32'(up_rdy), 32'd0);
    check("arst_dn_data", 32'(dn_data), 32'd0);
    modelReset();
    src_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix = '{8'd21, 8'd22, 8'd23, 8'd24};
    sendRun("arst_row", pix, 4, 8'hFF, 0);

    // Randomized rounds: random width, pad value, pixels and downstream stalls
    for (int r = 0; r < 4; r++) begin
      int            w;
      int            n;
      logic [IW-1:0] v;
      w = $urandom_range(1, 5);
      n = $urandom_range(5, 15);
      v = IW'($urandom);
      pix.delete();
      for (int i = 0; i < n; i++) pix.push_back(IW'($urandom));
      sendRun("rand", pix, w, v, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
